// File: rtl/bram_req_ctrl.sv
// In-order request front-end for the BRAM wrapper: buffers read/write commands,
// issues one at a time and returns read data (or a timeout error) on a response channel.
module bram_req_ctrl #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_we,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [DATA_WIDTH-1:0]            req_wdata,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic                             mem_en,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_din,
  input  logic [DATA_WIDTH-1:0]            mem_dout,
  input  logic                             mem_valid,
  output logic                             busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = $clog2(FIFO_DEPTH+1);
  localparam int CNT_W   = $clog2(TIMEOUT+1);
  localparam int ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t state, next_state;

  logic [ENTRY_W-1:0]    fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [LVL_W-1:0]      count;
  logic                  push, pop;

  logic                  cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_din;
  logic [CNT_W-1:0]      tmo_cnt;
  logic                  tmo_hit;

  assign req_ready = (count != LVL_W'(FIFO_DEPTH));
  assign push      = req_valid && req_ready;
  assign tmo_hit   = (tmo_cnt == CNT_W'(TIMEOUT));

  // FIFO storage carries no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {req_we, req_addr, req_wdata};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE:   next_state = cmd_we ? IDLE : WAIT_RD;
      WAIT_RD: if (mem_valid || tmo_hit) next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Command registers double as the wrapper address/data, so they hold after issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_din   <= '0;
      tmo_cnt   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (pop) {cmd_we, cmd_addr, cmd_din} <= fifo_mem[rd_ptr];
      if (state == ISSUE) tmo_cnt <= CNT_W'(1);
      if (state == WAIT_RD) begin
        if (mem_valid) begin
          rsp_rdata <= mem_dout;
          rsp_err   <= 1'b0;
        end else if (tmo_hit) begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b1;
        end else begin
          tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign mem_en     = (state == ISSUE);
  assign mem_we     = (state == ISSUE) && cmd_we;
  assign mem_addr   = cmd_addr;
  assign mem_din    = cmd_din;
  assign rsp_valid  = (state == RESP);
  assign busy       = (state != IDLE) || (count != '0);
  assign fifo_level = count;

endmodule

// File: tb/tb_bram_req_ctrl.sv
// Directed bench for bram_req_ctrl with a small behavioural BRAM-wrapper read model.
module tb_bram_req_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid, req_ready, req_we;
  logic [14:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_en, mem_we, mem_valid;
  logic [14:0] mem_addr;
  logic [31:0] mem_din, mem_dout;
  logic        busy;
  logic [2:0]  fifo_level;

  int n_chk  = 0;
  int n_pass = 0;

  int          rd_lat = 3;
  logic [14:0] m_addr;
  int          m_lat;

  always #5 clk = ~clk;

  bram_req_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_valid(mem_valid),
    .busy(busy), .fifo_level(fifo_level)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rd_data(input logic [14:0] a);
    if (a == 15'h0010) return 32'hDEADBEEF;
    return 32'hA500_0000 | {17'd0, a};
  endfunction

  // Wrapper read model: mem_valid rd_lat cycles after the issue cycle; rd_lat=0 never answers.
  initial begin
    mem_valid = 1'b0;
    mem_dout  = '0;
    forever begin
      @(negedge clk);
      if (rst && mem_en && !mem_we && rd_lat > 0) begin
        m_addr = mem_addr;
        m_lat  = rd_lat;
        repeat (m_lat) @(posedge clk);
        #1;
        mem_valid = 1'b1;
        mem_dout  = rd_data(m_addr);
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        mem_dout  = '0;
      end
    end
  end

  task automatic run_reads(input int n, input logic [14:0] base, input int hold);
    int sent;
    int rcv;
    sent      = 0;
    rcv       = 0;
    rsp_ready = (hold == 0);
    req_we    = 1'b0;
    req_valid = 1'b1;
    req_addr  = base;
    for (int c = 0; c < 300 && rcv < n; c++) begin
      @(negedge clk);
      check("ready_vs_level", req_ready, fifo_level != 3'd4);
      if (hold > 0 && c == hold - 1) begin
        check("bp_level", fifo_level, 4);
        check("bp_req_ready", req_ready, 0);
        check("bp_rsp_valid", rsp_valid, 1);
        check("bp_rsp_rdata", rsp_rdata, rd_data(base));
        check("bp_rsp_err", rsp_err, 0);
      end
      if (rsp_valid && rsp_ready) begin
        check("rd_order_rdata", rsp_rdata, rd_data(15'(base + rcv)));
        check("rd_order_err", rsp_err, 0);
        rcv++;
      end
      if (req_valid && req_ready) sent++;
      tick();
      if (c == hold - 1) rsp_ready = 1'b1;
      if (sent < n) begin
        req_valid = 1'b1;
        req_addr  = 15'(base + sent);
      end else begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    check("rd_rsp_count", rcv, n);
    tick();
  endtask

  initial begin
    int nresp;
    int nbad;

    // Reset with random inputs
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = 15'($urandom);
      req_wdata = $urandom;
      rsp_ready = 1'($urandom_range(0, 1));
      tick();
    end
    @(negedge clk);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_din", mem_din, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_busy", busy, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_req_ready", req_ready, 1);
    tick();
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    rst = 1'b1;
    tick();

    // Single read, wrapper latency 3
    rd_lat    = 3;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 15'h0010;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check("sr_mem_en", mem_en, k == 2);
      if (k == 2) begin
        check("sr_mem_we", mem_we, 0);
        check("sr_mem_addr", mem_addr, 15'h0010);
      end
      check("sr_rsp_valid", rsp_valid, k >= 6);
      if (k == 6) begin
        check("sr_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
        check("sr_rsp_err", rsp_err, 0);
      end
      tick();
      if (k == 0) req_valid = 1'b0;
      if (k == 7) rsp_ready = 1'b1;
    end
    @(negedge clk);
    check("sr_rsp_drop", rsp_valid, 0);
    check("sr_idle", busy, 0);
    tick();

    // Back-pressure: six reads with rsp_ready held low
    run_reads(6, 15'h0100, 12);
    repeat (2) tick();

    // Write then read to the same address
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 15'd5; req_wdata = 32'h1234_5678;
    nresp = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("wr_mem_en", mem_en, (k == 2) || (k == 4));
      if (k == 2) begin
        check("wr_mem_we", mem_we, 1);
        check("wr_mem_din", mem_din, 32'h1234_5678);
        check("wr_mem_addr", mem_addr, 5);
      end
      if (k == 4) begin
        check("wr_rd_mem_we", mem_we, 0);
        check("wr_rd_mem_addr", mem_addr, 5);
      end
      if (rsp_valid && rsp_ready) begin
        nresp++;
        check("wr_rd_rdata", rsp_rdata, rd_data(15'd5));
        check("wr_rd_cycle", k, 8);
      end
      tick();
      if (k == 0) req_we = 1'b0;
      if (k == 1) req_valid = 1'b0;
    end
    check("wr_rd_nresp", nresp, 1);

    // Timeout, then mem_valid on the last WAIT_RD cycle
    for (int t = 0; t < 2; t++) begin
      rd_lat    = (t == 0) ? 0 : 15;
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_we = 1'b0; req_addr = (t == 0) ? 15'h0020 : 15'h0021;
      for (int k = 0; k < 21; k++) begin
        @(negedge clk);
        check("to_rsp_valid", rsp_valid, k == 18);
        if (k == 18) begin
          check("to_rsp_err", rsp_err, (t == 0) ? 1 : 0);
          check("to_rsp_rdata", rsp_rdata, (t == 0) ? 32'd0 : rd_data(15'h0021));
        end
        tick();
        if (k == 0) req_valid = 1'b0;
      end
    end

    // Reset while a read waits and two commands are queued
    rd_lat    = 0;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 15'h0030;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) begin
        @(negedge clk);
        check("mr_busy", busy, 1);
        check("mr_level", fifo_level, 2);
      end
      tick();
      if (k < 2) req_addr = 15'(15'h0031 + k);
      else req_valid = 1'b0;
    end
    rst = 1'b0;
    @(negedge clk);
    check("mr_rst_level", fifo_level, 0);
    check("mr_rst_rsp_valid", rsp_valid, 0);
    tick();
    tick();
    rst = 1'b1;
    rsp_ready = 1'b1;
    nbad = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (rsp_valid || mem_en || fifo_level != 3'd0) nbad++;
      tick();
    end
    check("mr_no_activity", nbad, 0);
    rd_lat = 3;
    run_reads(1, 15'h0040, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
